play_seq: RTL and testbench

Playback sequencer for the audio recorder's SRAM-to-DAC path. It fetches recorded 16-bit samples from SRAM and paces playback against the DAC sample strobe. Per output sample it presents a sample pair (current, next) and a 3-bit interpolation index, which the downstream slow-motion interpolator consumes. Slow modes repeat each stored sample N times with a rising index; fast modes skip samples by a fixed step.

---
 rtl/audio_pkg.sv | 27 ++
 rtl/play_seq_if.sv | 13 +
 rtl/play_rate_cnt.sv | 47 ++++
 rtl/play_seq.sv | 203 ++++++++++++++++++++
 tb/tb_play_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared playback types, widths and rate decode helpers
package audio_pkg;

   localparam int         AUDIO_ADDR_W = 20;
   localparam int         AUDIO_DATA_W = 16;
   localparam logic [3:0] SPEED_NORMAL = 4'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH1,
      ST_FETCH2,
      ST_WAIT,
      ST_DONE
   } play_state_t;

   // Last index of a repeat group (N-1); fast and normal speed never repeat.
   function automatic logic [2:0] rep_last(input logic fast, input logic [3:0] speed);
      if (fast || speed >= SPEED_NORMAL) return 3'd0;
      return 3'd7 - speed[2:0];
   endfunction

   function automatic logic [3:0] step_of(input logic fast, input logic [3:0] speed);
      if (fast) return {1'b0, speed[2:0]} + 4'd1;
      return 4'd1;
   endfunction

endpackage

// File: rtl/play_seq_if.sv
// rtl/play_seq_if.sv - SRAM read port between the playback sequencer and sample memory
interface play_seq_if import audio_pkg::*; #(
   parameter int ADDR_W = AUDIO_ADDR_W,
   parameter int DATA_W = AUDIO_DATA_W
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   modport master (output rd_req, output rd_addr, input rd_valid, input rd_data);
   modport slave  (input rd_req, input rd_addr, output rd_valid, output rd_data);
endinterface

// File: rtl/play_rate_cnt.sv
// rtl/play_rate_cnt.sv - speed/fast latch, repeat/step decode and interpolation index counter
module play_rate_cnt import audio_pkg::*; (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clear,
   input  logic       i_fire,
   input  logic       i_fast,
   input  logic [3:0] i_speed,
   output logic [2:0] o_count,
   output logic       o_advance,
   output logic [3:0] o_step
);
   logic       fast_q, fast_d;
   logic [3:0] speed_q, speed_d;
   logic [2:0] count_q, count_d;

   assign o_advance = i_fire && (count_q == rep_last(fast_q, speed_q));
   assign o_step    = step_of(fast_q, speed_q);
   assign o_count   = count_q;

   // Settings are resampled only when a group closes, so a group never changes length mid-way.
   always_comb begin
      fast_d  = fast_q;
      speed_d = speed_q;
      count_d = count_q;
      if (i_clear || o_advance) begin
         fast_d  = i_fast;
         speed_d = i_speed;
         count_d = '0;
      end else if (i_fire) begin
         count_d = count_q + 3'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fast_q  <= 1'b0;
         speed_q <= '0;
         count_q <= '0;
      end else begin
         fast_q  <= fast_d;
         speed_q <= speed_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/play_seq.sv
// rtl/play_seq.sv - SRAM-to-DAC playback sequencer; PLAY_SEQ_UNDERRUN_CNT_EN adds o_underrun_cnt
module play_seq import audio_pkg::*; #(
   parameter int ADDR_W = AUDIO_ADDR_W,
   parameter int DATA_W = AUDIO_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_pause,
   input  logic              i_fast,
   input  logic [3:0]        i_speed,
   input  logic [ADDR_W-1:0] i_end_addr,
   input  logic              i_sample_req,
   play_seq_if.master        rd,
   output logic [DATA_W-1:0] o_data1,
   output logic [DATA_W-1:0] o_data2,
   output logic [2:0]        o_count_inter,
   output logic              o_sample_valid,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_busy,
`ifdef PLAY_SEQ_UNDERRUN_CNT_EN
   output logic [7:0]        o_underrun_cnt,
`endif
   output logic              o_done
);
   play_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
   logic              sent_q, sent_d;
   logic              pend_q, pend_d;
   logic              rdout_q, rdout_d;
   logic [DATA_W-1:0] out1_q, out1_d, out2_q, out2_d;
   logic [2:0]        outcnt_q, outcnt_d;
   logic [ADDR_W-1:0] outaddr_q, outaddr_d;
   logic              valid_q, valid_d;

   logic              fetching, rd_req, fire, start_go, clear, advance;
   logic [3:0]        step;
   logic [2:0]        count;
   logic [ADDR_W:0]   next_addr, end_ext;

   assign fetching  = (state_q == ST_FETCH1) || (state_q == ST_FETCH2);
   assign start_go  = (state_q == ST_IDLE) && i_start && !i_stop;
   assign clear     = i_stop || start_go;
   assign fire      = (state_q == ST_WAIT) && !i_stop && !i_pause && (i_sample_req || pend_q);
   // rdout_q survives a stop so a fresh fetch never overlaps a read still in flight.
   assign rd_req    = fetching && !i_stop && !sent_q && !rdout_q;
   assign rdout_d   = rd_req || (rdout_q && !rd.rd_valid);
   assign next_addr = {1'b0, addr_q} + (ADDR_W+1)'(step);
   assign end_ext   = {1'b0, i_end_addr};

   assign rd.rd_req  = rd_req;
   assign rd.rd_addr = !rd_req ? '0 :
                       (state_q == ST_FETCH2) ? addr_q + ADDR_W'(1) : addr_q;

   play_rate_cnt u_rate (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clear   (clear),
      .i_fire    (fire),
      .i_fast    (i_fast),
      .i_speed   (i_speed),
      .o_count   (count),
      .o_advance (advance),
      .o_step    (step)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      d1_d      = d1_q;
      d2_d      = d2_q;
      sent_d    = sent_q;
      pend_d    = pend_q;
      out1_d    = out1_q;
      out2_d    = out2_q;
      outcnt_d  = outcnt_q;
      outaddr_d = outaddr_q;
      valid_d   = 1'b0;
      if (i_stop) begin
         state_d = ST_IDLE;
         pend_d  = 1'b0;
         sent_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  addr_d  = '0;
                  pend_d  = 1'b0;
                  state_d = ST_FETCH1;
               end
            end
            ST_FETCH1, ST_FETCH2: begin
               if (i_sample_req) pend_d = 1'b1;
               if (rd_req) begin
                  sent_d = 1'b1;
               end else if (sent_q && rd.rd_valid) begin
                  sent_d = 1'b0;
                  if (state_q == ST_FETCH2) begin
                     d2_d    = rd.rd_data;
                     state_d = ST_WAIT;
                  end else begin
                     d1_d = rd.rd_data;
                     if (addr_q == i_end_addr) begin
                        d2_d    = rd.rd_data;
                        state_d = ST_WAIT;
                     end else begin
                        state_d = ST_FETCH2;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (fire) begin
                  pend_d    = 1'b0;
                  valid_d   = 1'b1;
                  out1_d    = d1_q;
                  out2_d    = d2_q;
                  outcnt_d  = count;
                  outaddr_d = addr_q;
                  if (advance) begin
                     if (next_addr > end_ext) begin
                        state_d = ST_DONE;
                     end else begin
                        addr_d = next_addr[ADDR_W-1:0];
                        if (step == 4'd1) begin
                           // Sliding by one: the old "next" becomes current; at the end it pairs with itself.
                           d1_d    = d2_q;
                           state_d = (next_addr == end_ext) ? ST_WAIT : ST_FETCH2;
                        end else begin
                           state_d = ST_FETCH1;
                        end
                     end
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         d1_q      <= '0;
         d2_q      <= '0;
         sent_q    <= 1'b0;
         pend_q    <= 1'b0;
         rdout_q   <= 1'b0;
         out1_q    <= '0;
         out2_q    <= '0;
         outcnt_q  <= '0;
         outaddr_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         sent_q    <= sent_d;
         pend_q    <= pend_d;
         rdout_q   <= rdout_d;
         out1_q    <= out1_d;
         out2_q    <= out2_d;
         outcnt_q  <= outcnt_d;
         outaddr_q <= outaddr_d;
         valid_q   <= valid_d;
      end
   end

`ifdef PLAY_SEQ_UNDERRUN_CNT_EN
   logic       drop;
   logic [7:0] urun_q, urun_d;

   assign drop = i_sample_req && pend_q && !i_stop &&
                 (fetching || ((state_q == ST_WAIT) && !i_pause));

   always_comb begin
      urun_d = urun_q;
      if (start_go)                    urun_d = '0;
      else if (drop && urun_q != 8'hFF) urun_d = urun_q + 8'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) urun_q <= '0;
      else          urun_q <= urun_d;
   end

   assign o_underrun_cnt = urun_q;
`endif

   assign o_data1        = out1_q;
   assign o_data2        = out2_q;
   assign o_count_inter  = outcnt_q;
   assign o_sample_valid = valid_q;
   assign o_addr         = outaddr_q;
   assign o_busy         = (state_q != ST_IDLE);
   assign o_done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_play_seq.sv
// tb/tb_play_seq.sv - self-checking bench for play_seq against a sample-list reference model
module tb_play_seq;
   localparam int AW = 20;
   localparam int DW = 16;

   typedef struct {
      int d1;
      int d2;
      int cnt;
      int addr;
   } trip_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, stop, pause, fast, sreq;
   logic [3:0]    speed;
   logic [AW-1:0] end_addr;
   logic [DW-1:0] data1, data2;
   logic [2:0]    cnt;
   logic          svalid, busy, done;
   logic [AW-1:0] paddr;
`ifdef PLAY_SEQ_UNDERRUN_CNT_EN
   logic [7:0]    urun;
`endif

   logic [DW-1:0] mem [0:15];
   trip_t         expq[$];
   trip_t         e;
   int            n_chk = 0, n_bad = 0;
   int            done_cnt = 0, reads = 0;
   int            lat = 1, sram_cnt = 0;
   logic [AW-1:0] sram_addr;
   int            last_d1 = 0, last_d2 = 0;

   play_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   play_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_stop         (stop),
      .i_pause        (pause),
      .i_fast         (fast),
      .i_speed        (speed),
      .i_end_addr     (end_addr),
      .i_sample_req   (sreq),
      .rd             (bus),
      .o_data1        (data1),
      .o_data2        (data2),
      .o_count_inter  (cnt),
      .o_sample_valid (svalid),
      .o_addr         (paddr),
      .o_busy         (busy),
`ifdef PLAY_SEQ_UNDERRUN_CNT_EN
      .o_underrun_cnt (urun),
`endif
      .o_done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // SRAM responder with a per-run latency.
   always @(posedge clk) begin
      bus.rd_valid <= 1'b0;
      if (sram_cnt != 0) begin
         sram_cnt <= sram_cnt - 1;
         if (sram_cnt == 1) begin
            bus.rd_valid <= 1'b1;
            bus.rd_data  <= mem[sram_addr[3:0]];
         end
      end else if (bus.rd_req) begin
         sram_addr <= bus.rd_addr;
         sram_cnt  <= lat;
         reads     <= reads + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_cnt++;
         if (svalid) begin
            if (expq.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("data1", int'(data1), e.d1);
               chk("data2", int'(data2), e.d2);
               chk("count", int'(cnt), e.cnt);
               chk("addr", int'(paddr), e.addr);
               last_d1 = e.d1;
               last_d2 = e.d2;
            end
         end
      end
   end

   task automatic push_exp(input int d1, input int d2, input int c, input int a);
      trip_t t;
      t.d1 = d1; t.d2 = d2; t.cnt = c; t.addr = a;
      expq.push_back(t);
   endtask

   // Whole-playback reference: which samples are visited, how often, and how many reads it costs.
   task automatic build_model(input logic f, input logic [3:0] sp, input int ea,
                              output int n_exp, output int n_rd);
      int n, s, a;
      bit first;
      n = f ? 1 : ((int'(sp) >= 7) ? 1 : 8 - int'(sp));
      s = f ? (int'(sp) % 8) + 1 : 1;
      a = 0; n_exp = 0; n_rd = 0; first = 1'b1;
      while (a <= ea) begin
         if (first || s > 1) n_rd++;
         if (a < ea) n_rd++;
         first = 1'b0;
         for (int c = 0; c < n; c++) begin
            push_exp(int'(mem[a]), (a < ea) ? int'(mem[a+1]) : int'(mem[a]), c, a);
            n_exp++;
         end
         a += s;
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("start_rdreq", int'(bus.rd_req), 1);
      chk("start_rdaddr", int'(bus.rd_addr), 0);
   endtask

   task automatic pulse_stop();
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
   endtask

   task automatic pulse_req(input int gap);
      @(posedge clk); #1 sreq = 1'b1;
      @(posedge clk); #1 sreq = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic run_play(input logic f, input logic [3:0] sp, input int ea);
      int n_exp, n_rd, d0, r0, t;
      fast = f; speed = sp; end_addr = AW'(ea);
      build_model(f, sp, ea, n_exp, n_rd);
      d0 = done_cnt;
      r0 = reads;
      pulse_start();
      repeat (n_exp) begin
         repeat (3) @(posedge clk);
         pulse_req(16);
      end
      t = 0;
      while (done_cnt == d0 && t < 60) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("done_pulses", done_cnt - d0, 1);
      chk("idle_after_done", int'(busy), 0);
      chk("reads", reads - r0, n_rd);
      chk("left_in_queue", expq.size(), 0);
      expq.delete();
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      start = 0; stop = 0; pause = 0; fast = 0; speed = 4'd7; end_addr = '0; sreq = 0;
      rst_n = 1'b0;
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;
      for (int i = 0; i < 16; i++) mem[i] = DW'(100 * (i + 1));
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(svalid), 0);
      chk("rst_data1", int'(data1), 0);
      chk("rst_data2", int'(data2), 0);
      chk("rst_count", int'(cnt), 0);
      chk("rst_addr", int'(paddr), 0);
      chk("rst_rdreq", int'(bus.rd_req), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;

      lat = 2; run_play(1'b0, 4'd7, 2);
      lat = 3; run_play(1'b1, 4'd2, 9);
      lat = 1; run_play(1'b0, 4'd5, 3);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
         lat = $urandom_range(1, 4);
         run_play(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 12));
      end

      // Pause in the middle of a slow group, then finish the group and advance.
      for (int i = 0; i < 16; i++) mem[i] = DW'(100 * (i + 1));
      lat = 2; fast = 1'b0; speed = 4'd0; end_addr = AW'(2);
      pulse_start();
      repeat (30) @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         push_exp(100, 200, c, 0);
         pulse_req(4);
      end
      pause = 1'b1;
      repeat (5) pulse_req(4);
      pause = 1'b0;
      push_exp(100, 200, 3, 0);
      pulse_req(4);
      for (int c = 4; c < 8; c++) push_exp(100, 200, c, 0);
      push_exp(200, 300, 0, 1);
      repeat (5) pulse_req(20);
      chk("pause_queue", expq.size(), 0);
      pulse_stop();

      // Two requests inside one slow fetch: one serviced, one dropped.
      lat = 4; speed = 4'd7; end_addr = AW'(5);
      push_exp(100, 200, 0, 0);
      pulse_start();
      pulse_req(1);
      pulse_req(1);
      repeat (30) @(posedge clk);
      chk("underrun_queue", expq.size(), 0);
`ifdef PLAY_SEQ_UNDERRUN_CNT_EN
      chk("underrun_cnt", int'(urun), 1);
`endif
      pulse_stop();
      repeat (10) @(posedge clk);

      // Stop with a read in flight; the late data must not disturb anything.
      pulse_start();
      repeat (2) @(posedge clk);
      pulse_stop();
      chk("stop_busy", int'(busy), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("stop_busy_late", int'(busy), 0);
      chk("stop_data1", int'(data1), last_d1);
      chk("stop_data2", int'(data2), last_d2);
      push_exp(100, 200, 0, 0);
      pulse_start();
      repeat (30) @(posedge clk);
      pulse_req(20);
      chk("restart_queue", expq.size(), 0);
      pulse_stop();
      repeat (5) @(posedge clk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
